// File: rtl/tlb_pkg.sv
// Shared types for the multi-port TLB: packed entry layout, search result,
// INVTLB op codes and the match helpers used by lookup and sweep logic.
package tlb_pkg;

  localparam int TLB_ENTRY_W = 89;
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd22;

  localparam int OFF_E    = 88;
  localparam int OFF_VPPN = 69;
  localparam int OFF_PS   = 63;
  localparam int OFF_ASID = 53;
  localparam int OFF_G    = 52;
  localparam int OFF_PPN0 = 32;
  localparam int OFF_PLV0 = 30;
  localparam int OFF_MAT0 = 28;
  localparam int OFF_D0   = 27;
  localparam int OFF_V0   = 26;
  localparam int OFF_PPN1 = 6;
  localparam int OFF_PLV1 = 4;
  localparam int OFF_MAT1 = 2;
  localparam int OFF_D1   = 1;
  localparam int OFF_V1   = 0;

  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G1         = 5'd2;
  localparam logic [4:0] INV_G0         = 5'd3;
  localparam logic [4:0] INV_G0_ASID    = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic        found;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } srch_res_t;

  typedef enum logic {ST_IDLE, ST_SWEEP} inv_st_e;

  // VA compare ignores E; a 4MB page only compares vppn[18:10].
  function automatic logic va_match(tlb_entry_t ent, logic [18:0] vppn);
    return (ent.vppn[18:10] == vppn[18:10]) &&
           ((ent.ps == PS_4M) || (ent.vppn[9:0] == vppn[9:0]));
  endfunction

  function automatic logic inv_match(tlb_entry_t ent, logic [4:0] op,
                                     logic [9:0] asid, logic [18:0] vppn);
    logic va, am;
    va = va_match(ent, vppn);
    am = (ent.asid == asid);
    case (op)
      INV_ALL0, INV_ALL1: return 1'b1;
      INV_G1:             return ent.g;
      INV_G0:             return !ent.g;
      INV_G0_ASID:        return !ent.g && am;
      INV_G0_ASID_VA:     return !ent.g && am && va;
      INV_GA_VA:          return (ent.g || am) && va;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tlb_lookup.sv
// Combinational search of all entries for one port: match, lowest-index
// priority, odd/even page select. Registered by the parent.
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IW     = $clog2(TLBNUM)
) (
  input  tlb_entry_t [TLBNUM-1:0] ents_i,
  input  logic [18:0]             vppn_i,
  input  logic                    va_bit12_i,
  input  logic [9:0]              asid_i,
  output srch_res_t               res_o,
  output logic [IW-1:0]           index_o
);

  logic          hit, odd;
  logic [IW-1:0] hidx;

  always_comb begin
    hit  = 1'b0;
    hidx = '0;
    // Walk downward so the lowest matching index is the last one kept.
    for (int i = TLBNUM-1; i >= 0; i--) begin
      if (ents_i[i].e && va_match(ents_i[i], vppn_i) &&
          (ents_i[i].g || (ents_i[i].asid == asid_i))) begin
        hit  = 1'b1;
        hidx = IW'(i);
      end
    end
    odd     = (ents_i[hidx].ps == PS_4M) ? vppn_i[9] : va_bit12_i;
    res_o   = '0;
    index_o = '0;
    if (hit) begin
      index_o     = hidx;
      res_o.found = 1'b1;
      res_o.ps    = ents_i[hidx].ps;
      res_o.ppn   = odd ? ents_i[hidx].ppn1 : ents_i[hidx].ppn0;
      res_o.plv   = odd ? ents_i[hidx].plv1 : ents_i[hidx].plv0;
      res_o.mat   = odd ? ents_i[hidx].mat1 : ents_i[hidx].mat0;
      res_o.d     = odd ? ents_i[hidx].d1   : ents_i[hidx].d0;
      res_o.v     = odd ? ents_i[hidx].v1   : ents_i[hidx].v0;
    end
  end

endmodule

// File: rtl/tlb_mp.sv
// Multi-port TLB: NSPORT registered search ports, registered read port,
// one write port and a lane-parallel INVTLB sweep engine.
module tlb_mp
  import tlb_pkg::*;
#(
  parameter int TLBNUM    = 16,
  parameter int NSPORT    = 2,
  parameter int INV_LANES = 4
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic [NSPORT-1:0]                         s_req,
  input  logic [NSPORT-1:0][18:0]                   s_vppn,
  input  logic [NSPORT-1:0]                         s_va_bit12,
  input  logic [NSPORT-1:0][9:0]                    s_asid,
  output logic [NSPORT-1:0]                         s_rvalid,
  output logic [NSPORT-1:0]                         s_found,
  output logic [NSPORT-1:0][$clog2(TLBNUM)-1:0]     s_index,
  output logic [NSPORT-1:0][19:0]                   s_ppn,
  output logic [NSPORT-1:0][5:0]                    s_ps,
  output logic [NSPORT-1:0][1:0]                    s_plv,
  output logic [NSPORT-1:0][1:0]                    s_mat,
  output logic [NSPORT-1:0]                         s_d,
  output logic [NSPORT-1:0]                         s_v,
  input  logic                                      we,
  input  logic [$clog2(TLBNUM)-1:0]                 w_index,
  input  logic [TLB_ENTRY_W-1:0]                    w_entry,
  input  logic                                      r_req,
  input  logic [$clog2(TLBNUM)-1:0]                 r_index,
  output logic                                      r_valid,
  output logic [TLB_ENTRY_W-1:0]                    r_entry,
  input  logic                                      inv_req,
  input  logic [4:0]                                inv_op,
  input  logic [9:0]                                inv_asid,
  input  logic [18:0]                               inv_vppn,
  output logic                                      inv_busy,
  output logic                                      inv_done,
  output logic                                      inv_err
);

  localparam int IW   = $clog2(TLBNUM);
  localparam int NGRP = TLBNUM / INV_LANES;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  tlb_entry_t [TLBNUM-1:0] ent_q, ents_c;
  tlb_entry_t              wr_ent;
  logic [TLBNUM-1:0]       e_q, e_d;
  inv_st_e                 st_q, st_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic                    done_q, done_d, err_q, err_d;
  logic [4:0]              op_q;
  logic [9:0]              asid_q;
  logic [18:0]             vppn_q;

  always_comb begin
    wr_ent    = tlb_entry_t'(w_entry);
    wr_ent.ps = (wr_ent.ps == PS_4M) ? PS_4M : PS_4K;
    for (int i = 0; i < TLBNUM; i++) begin
      ents_c[i]   = ent_q[i];
      ents_c[i].e = e_q[i];
    end
  end

  // Payload fields carry no reset; only E gates a match.
  always_ff @(posedge clk) begin
    if (we) ent_q[w_index] <= wr_ent;
  end

  always_comb begin
    e_d = e_q;
    for (int i = 0; i < TLBNUM; i++) begin
      if (st_q == ST_SWEEP && (i / INV_LANES) == int'(grp_q) &&
          inv_match(ents_c[i], op_q, asid_q, vppn_q))
        e_d[i] = 1'b0;
      if (we && int'(w_index) == i) e_d[i] = wr_ent.e;
    end
  end

  always_comb begin
    st_d   = st_q;
    grp_d  = grp_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (st_q)
      ST_IDLE: if (inv_req) begin
        if (inv_op <= INV_GA_VA) begin
          st_d  = ST_SWEEP;
          grp_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_SWEEP: begin
        grp_d = grp_q + GW'(1);
        if (int'(grp_q) == NGRP-1) begin
          st_d   = ST_IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q    <= '0;
      st_q   <= ST_IDLE;
      grp_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      op_q   <= '0;
      asid_q <= '0;
      vppn_q <= '0;
    end else begin
      e_q    <= e_d;
      st_q   <= st_d;
      grp_q  <= grp_d;
      done_q <= done_d;
      err_q  <= err_d;
      if (st_q == ST_IDLE && inv_req) begin
        op_q   <= inv_op;
        asid_q <= inv_asid;
        vppn_q <= inv_vppn;
      end
    end
  end

  assign inv_busy = (st_q == ST_SWEEP);
  assign inv_done = done_q;
  assign inv_err  = err_q;

  srch_res_t [NSPORT-1:0]         lk_res, res_q;
  logic [NSPORT-1:0][IW-1:0]      lk_idx, idx_q;
  logic [NSPORT-1:0]              rv_q;

  for (genvar p = 0; p < NSPORT; p++) begin : g_port
    tlb_lookup #(.TLBNUM(TLBNUM), .IW(IW)) u_lookup (
      .ents_i     (ents_c),
      .vppn_i     (s_vppn[p]),
      .va_bit12_i (s_va_bit12[p]),
      .asid_i     (s_asid[p]),
      .res_o      (lk_res[p]),
      .index_o    (lk_idx[p])
    );

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rv_q[p]  <= 1'b0;
        res_q[p] <= '0;
        idx_q[p] <= '0;
      end else begin
        rv_q[p] <= s_req[p];
        if (s_req[p]) begin
          res_q[p] <= lk_res[p];
          idx_q[p] <= lk_idx[p];
        end
      end
    end

    assign s_rvalid[p] = rv_q[p];
    assign s_found[p]  = res_q[p].found;
    assign s_index[p]  = idx_q[p];
    assign s_ppn[p]    = res_q[p].ppn;
    assign s_ps[p]     = res_q[p].ps;
    assign s_plv[p]    = res_q[p].plv;
    assign s_mat[p]    = res_q[p].mat;
    assign s_d[p]      = res_q[p].d;
    assign s_v[p]      = res_q[p].v;
  end

  logic                   rvld_q;
  logic [TLB_ENTRY_W-1:0] rent_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvld_q <= 1'b0;
      rent_q <= '0;
    end else begin
      rvld_q <= r_req;
      if (r_req) rent_q <= ents_c[r_index];
    end
  end

  assign r_valid = rvld_q;
  assign r_entry = rent_q;

endmodule

// File: tb/tb_tlb_mp.sv
// Randomized bench for tlb_mp against an array-of-entries reference model.
module tb_tlb_mp;
  import tlb_pkg::*;

  localparam int N  = 16;
  localparam int NP = 2;

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0] s_req = '0, s_va_bit12 = '0;
  logic [NP-1:0][18:0] s_vppn = '0;
  logic [NP-1:0][9:0]  s_asid = '0;
  logic [NP-1:0] s_rvalid, s_found, s_d, s_v;
  logic [NP-1:0][3:0]  s_index;
  logic [NP-1:0][19:0] s_ppn;
  logic [NP-1:0][5:0]  s_ps;
  logic [NP-1:0][1:0]  s_plv, s_mat;
  logic we = 1'b0, r_req = 1'b0, inv_req = 1'b0;
  logic [3:0] w_index = '0, r_index = '0;
  logic [TLB_ENTRY_W-1:0] w_entry = '0;
  logic r_valid, inv_busy, inv_done, inv_err;
  logic [TLB_ENTRY_W-1:0] r_entry;
  logic [4:0]  inv_op = '0;
  logic [9:0]  inv_asid = '0;
  logic [18:0] inv_vppn = '0;

  tlb_mp #(.TLBNUM(N), .NSPORT(NP), .INV_LANES(4)) dut (
    .clk(clk), .resetn(resetn),
    .s_req(s_req), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_rvalid(s_rvalid), .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn),
    .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_entry(r_entry),
    .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_busy(inv_busy), .inv_done(inv_done), .inv_err(inv_err)
  );

  tlb_entry_t m_ent [N];
  int checks = 0, errors = 0;

  // Reference: first valid entry (by index) whose page covers the VA and ASID.
  function automatic logic [36:0] m_search(logic [18:0] vppn, logic b12, logic [9:0] asid);
    tlb_entry_t t;
    logic big, odd;
    for (int i = 0; i < N; i++) begin
      t   = m_ent[i];
      big = (t.ps == 6'd22);
      if (t.e && t.vppn[18:10] == vppn[18:10] && (big || t.vppn[9:0] == vppn[9:0]) &&
          (t.g || t.asid == asid)) begin
        odd = big ? vppn[9] : b12;
        if (odd) return {1'b1, 4'(i), t.ppn1, t.ps, t.plv1, t.mat1, t.d1, t.v1};
        return {1'b1, 4'(i), t.ppn0, t.ps, t.plv0, t.mat0, t.d0, t.v0};
      end
    end
    return '0;
  endfunction

  function automatic void m_inv(logic [4:0] op, logic [9:0] asid, logic [18:0] vppn);
    logic va, am, g, hit;
    for (int i = 0; i < N; i++) begin
      va = m_ent[i].vppn[18:10] == vppn[18:10] &&
           (m_ent[i].ps == 6'd22 || m_ent[i].vppn[9:0] == vppn[9:0]);
      am = (m_ent[i].asid == asid);
      g  = m_ent[i].g;
      case (op)
        5'd0, 5'd1: hit = 1'b1;
        5'd2: hit = g;
        5'd3: hit = !g;
        5'd4: hit = !g && am;
        5'd5: hit = !g && am && va;
        5'd6: hit = (g || am) && va;
        default: hit = 1'b0;
      endcase
      if (hit) m_ent[i].e = 1'b0;
    end
  endfunction

  function automatic tlb_entry_t rand_ent(logic e, logic g);
    tlb_entry_t t;
    t.e = e; t.g = g;
    t.vppn = {9'($urandom_range(3)), 10'($urandom)};
    t.ps   = ($urandom_range(3) == 0) ? 6'd22 : 6'd12;
    if ($urandom_range(4) == 0) t.ps = 6'($urandom);
    t.asid = 10'($urandom_range(3));
    t.ppn0 = 20'($urandom); t.plv0 = 2'($urandom); t.mat0 = 2'($urandom);
    t.d0 = 1'($urandom); t.v0 = 1'($urandom);
    t.ppn1 = 20'($urandom); t.plv1 = 2'($urandom); t.mat1 = 2'($urandom);
    t.d1 = 1'($urandom); t.v1 = 1'($urandom);
    return t;
  endfunction

  task automatic do_write(int idx, tlb_entry_t ent);
    @(negedge clk); we = 1'b1; w_index = 4'(idx); w_entry = ent;
    @(negedge clk); we = 1'b0;
    m_ent[idx] = ent;
    m_ent[idx].ps = (ent.ps == 6'd22) ? 6'd22 : 6'd12;
  endtask

  task automatic query_for(int i, output logic [18:0] v, output logic b, output logic [9:0] a);
    v = m_ent[i].vppn;
    if (m_ent[i].ps == 6'd22) v[9:0] = 10'($urandom);
    b = 1'($urandom);
    a = ($urandom_range(1) == 1) ? m_ent[i].asid : 10'($urandom_range(3));
  endtask

  task automatic do_search(string name, logic [18:0] v0, logic b0, logic [9:0] a0,
                           logic [18:0] v1, logic b1, logic [9:0] a1);
    logic [36:0] exp [NP];
    logic [36:0] act;
    exp[0] = m_search(v0, b0, a0);
    exp[1] = m_search(v1, b1, a1);
    @(negedge clk);
    s_req = 2'b11; s_vppn[0] = v0; s_va_bit12[0] = b0; s_asid[0] = a0;
    s_vppn[1] = v1; s_va_bit12[1] = b1; s_asid[1] = a1;
    @(negedge clk); s_req = '0;
    for (int p = 0; p < NP; p++) begin
      act = {s_found[p], s_index[p], s_ppn[p], s_ps[p], s_plv[p], s_mat[p], s_d[p], s_v[p]};
      checks++;
      if (act !== exp[p] || s_rvalid[p] !== 1'b1) begin
        errors++;
        $display("FAIL %s port%0d: got %h rvalid=%b, want %h rvalid=1", name, p, act, s_rvalid[p], exp[p]);
      end
    end
  endtask

  task automatic check_all(string name);
    logic [18:0] v0, v1; logic b0, b1; logic [9:0] a0, a1;
    for (int i = 0; i < N; i++) begin
      query_for(i, v0, b0, a0);
      query_for(int'($urandom_range(N-1)), v1, b1, a1);
      do_search(name, v0, b0, a0, v1, b1, a1);
    end
  endtask

  task automatic fill(int gmode);
    for (int i = 0; i < N; i++)
      do_write(i, rand_ent(1'b1, (gmode == 1) ? 1'(i) : 1'($urandom)));
  endtask

  task automatic run_sweep(string name, logic [4:0] op, logic [9:0] asid, logic [18:0] vppn,
                           bit do_w, tlb_entry_t went);
    int cnt; bit ok;
    @(negedge clk); inv_req = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    @(negedge clk); inv_req = 1'b0;
    if (do_w) begin we = 1'b1; w_index = 4'd1; w_entry = went; end
    cnt = 0; ok = 1;
    while (inv_busy === 1'b1 && cnt < 20) begin
      if (inv_done !== 1'b0 || inv_err !== 1'b0) ok = 0;
      cnt++;
      if (cnt == 2) begin inv_req = 1'b1; inv_op = 5'd7; end
      @(negedge clk);
      we = 1'b0; inv_req = 1'b0;
    end
    checks++;
    if (cnt != N/4 || inv_done !== 1'b1 || !ok) begin
      errors++;
      $display("FAIL %s sweep: busy_cycles=%0d done=%b clean=%0d, want 4 1 1", name, cnt, inv_done, ok);
    end
    m_inv(op, asid, vppn);
    if (do_w) begin m_ent[1] = went; m_ent[1].ps = (went.ps == 6'd22) ? 6'd22 : 6'd12; end
    @(negedge clk);
    checks++;
    if (inv_done !== 1'b0 || inv_busy !== 1'b0 || inv_err !== 1'b0) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b err=%b, want 0 0 0", name, inv_done, inv_busy, inv_err);
    end
  endtask

  task automatic test_reset();
    logic [255:0] outs;
    repeat (3) @(negedge clk);
    outs = 256'({s_rvalid, s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
                 r_valid, r_entry, inv_busy, inv_done, inv_err});
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h, want 0", outs); end
    resetn = 1'b1;
    do_search("reset_miss", 19'h12345, 1'b0, 10'd5, 19'($urandom), 1'b1, 10'd0);
  endtask

  task automatic test_write_search();
    tlb_entry_t t;
    t = '0; t.e = 1; t.vppn = 19'h12345; t.ps = 6'd12; t.asid = 10'd5;
    t.ppn0 = 20'hAAAAA; t.ppn1 = 20'hBBBBB;
    do_write(3, t);
    do_search("write_search", 19'h12345, 1'b1, 10'd5, 19'h12345, 1'b0, 10'd5);
    checks++;
    if (s_found[0] !== 1'b1 || s_index[0] !== 4'd3 || s_ppn[0] !== 20'hBBBBB || s_ps[0] !== 6'd12) begin
      errors++;
      $display("FAIL write_search_const: got f=%b i=%0d ppn=%h ps=%0d, want 1 3 bbbbb 12",
               s_found[0], s_index[0], s_ppn[0], s_ps[0]);
    end
    @(negedge clk);
    checks++;
    if (s_rvalid !== 2'b00 || s_found[0] !== 1'b1 || s_ppn[0] !== 20'hBBBBB) begin
      errors++;
      $display("FAIL search_hold: got rvalid=%b found=%b ppn=%h, want 00 1 bbbbb", s_rvalid, s_found[0], s_ppn[0]);
    end
  endtask

  task automatic test_4m_priority();
    tlb_entry_t t;
    logic [18:0] q;
    for (int k = 0; k < 2; k++) begin
      t = rand_ent(1'b1, 1'b1);
      t.ps = 6'd22; t.vppn[18:10] = 9'h1AB;
      do_write(k == 0 ? 2 : 7, t);
    end
    q = {9'h1AB, 1'b0, 9'($urandom)};
    do_search("4m_priority", q, 1'($urandom), 10'($urandom), {9'h1AB, 10'($urandom)}, 1'b0, 10'd9);
    checks++;
    if (s_index[0] !== 4'd2 || s_ppn[0] !== m_ent[2].ppn0 || s_ps[0] !== 6'd22) begin
      errors++;
      $display("FAIL 4m_priority_const: got i=%0d ppn=%h ps=%0d, want 2 %h 22", s_index[0], s_ppn[0], s_ps[0], m_ent[2].ppn0);
    end
  endtask

  task automatic test_e0_miss();
    tlb_entry_t t;
    t = rand_ent(1'b0, 1'b1); t.vppn = 19'h7F0F0; t.ps = 6'd12;
    do_write(5, t);
    do_search("e0_miss", 19'h7F0F0, 1'b0, 10'd0, 19'h7F0F0, 1'b1, 10'd3);
    checks++;
    if ({s_found, s_ppn, s_ps, s_index} !== '0) begin
      errors++;
      $display("FAIL e0_miss_const: got found=%b ppn=%h, want all zero", s_found, s_ppn);
    end
  endtask

  task automatic test_random_search();
    logic [18:0] v0, v1; logic b0, b1; logic [9:0] a0, a1;
    fill(0);
    for (int n = 0; n < 30; n++) begin
      query_for(int'($urandom_range(N-1)), v0, b0, a0);
      if (n % 3 == 0) v0 = 19'($urandom);
      query_for(int'($urandom_range(N-1)), v1, b1, a1);
      do_search("random_search", v0, b0, a0, v1, b1, a1);
    end
  endtask

  task automatic test_read();
    int i;
    for (int n = 0; n < 6; n++) begin
      i = int'($urandom_range(N-1));
      @(negedge clk); r_req = 1'b1; r_index = 4'(i);
      @(negedge clk); r_req = 1'b0;
      checks++;
      if (r_valid !== 1'b1 || r_entry !== TLB_ENTRY_W'(m_ent[i])) begin
        errors++;
        $display("FAIL read idx%0d: got v=%b %h, want 1 %h", i, r_valid, r_entry, m_ent[i]);
      end
    end
  endtask

  task automatic test_inv_op3();
    fill(1);
    run_sweep("inv_op3", 5'd3, 10'd0, 19'd0, 0, '0);
    check_all("inv_op3");
  endtask

  task automatic test_inv_err();
    @(negedge clk); inv_req = 1'b1; inv_op = 5'd7;
    @(negedge clk); inv_req = 1'b0;
    checks++;
    if (inv_err !== 1'b1 || inv_busy !== 1'b0) begin
      errors++; $display("FAIL inv_err_pulse: got err=%b busy=%b, want 1 0", inv_err, inv_busy);
    end
    @(negedge clk);
    checks++;
    if (inv_err !== 1'b0 || inv_busy !== 1'b0 || inv_done !== 1'b0) begin
      errors++; $display("FAIL inv_err_after: got err=%b busy=%b done=%b, want 0 0 0", inv_err, inv_busy, inv_done);
    end
    check_all("inv_err_nochange");
  endtask

  task automatic test_inv_ops();
    logic [4:0] ops [4] = '{5'd2, 5'd4, 5'd5, 5'd6};
    logic [18:0] v; logic b; logic [9:0] a;
    int j;
    for (int k = 0; k < 4; k++) begin
      fill(0);
      j = int'($urandom_range(N-1));
      query_for(j, v, b, a);
      run_sweep("inv_ops", ops[k], m_ent[j].asid, v, 0, '0);
      check_all("inv_ops");
    end
    test_read();
  endtask

  task automatic test_inv_race();
    tlb_entry_t t;
    fill(0);
    t = rand_ent(1'b1, 1'b1);
    run_sweep("inv_race", 5'd0, 10'd0, 19'd0, 1, t);
    check_all("inv_race");
  endtask

  task automatic test_inv_reset();
    int seen;
    fill(0);
    @(negedge clk); inv_req = 1'b1; inv_op = 5'd0;
    @(negedge clk); inv_req = 1'b0;
    @(negedge clk); resetn = 1'b0;
    #1;
    checks++;
    if (inv_busy !== 1'b0 || inv_done !== 1'b0 || s_found !== '0 || s_rvalid !== '0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b found=%b, want 0 0 00", inv_busy, inv_done, s_found);
    end
    for (int i = 0; i < N; i++) m_ent[i].e = 1'b0;
    @(negedge clk); resetn = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (inv_done !== 1'b0 || inv_busy !== 1'b0) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_no_done: got %0d active cycles, want 0", seen); end
    check_all("reset_abort_miss");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) m_ent[i] = '0;
    test_reset();
    test_write_search();
    test_4m_priority();
    test_e0_miss();
    test_random_search();
    test_read();
    test_inv_op3();
    test_inv_err();
    test_inv_ops();
    test_inv_race();
    test_inv_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_mp.md
# tlb_mp

Parametrised, multi-port successor TLB for the LoongArch pipeline: TLBNUM fully associative entries, NSPORT independent search ports with a one-cycle registered lookup, a registered read port, one write port, and a multi-cycle INVTLB sweep engine with a busy/done handshake. It sits between IF/EX and the CSR/TLB-instruction unit, and replaces the single-cycle 2-port TLB. Entry match now requires E=1.

## Interface
- TLBNUM, 16: entry count; power of two, 4..64.
- NSPORT, 2: search ports; port 0 fetch, port 1 load/store, others spare.
- INV_LANES, 4: entries examined per INVTLB cycle; power of two, must divide TLBNUM.
- clk  input  1  clock.
- resetn  input  1  reset; asynchronous assertion, active-low.
- s_req  input  NSPORT  per-port lookup request, sampled each clk.
- s_vppn  input  NSPORT*19  VA[31:13] per port.
- s_va_bit12  input  NSPORT  VA[12] per port.
- s_asid  input  NSPORT*10  ASID per port.
- s_rvalid  output  NSPORT  result valid, one cycle after s_req.
- s_found  output  NSPORT  hit.
- s_index  output  NSPORT*log2(TLBNUM)  hit index.
- s_ppn  output  NSPORT*20  selected page PPN.
- s_ps  output  NSPORT*6  page size: 12 or 22.
- s_plv / s_mat  output  NSPORT*2 each  PLV / MAT of selected page.
- s_d / s_v  output  NSPORT each  D / V of selected page.
- we  input  1  write strobe.
- w_index  input  log2(TLBNUM)  write index.
- w_entry  input  TLB_ENTRY_W  packed entry (tlb_pkg layout).
- r_req  input  1  read request.
- r_index  input  log2(TLBNUM)  read index.
- r_valid  output  1  read data valid, one cycle after r_req.
- r_entry  output  TLB_ENTRY_W  packed entry read.
- inv_req  input  1  INVTLB start; accepted only when inv_busy=0.
- inv_op  input  5  INVTLB op.
- inv_asid  input  10  ASID operand.
- inv_vppn  input  19  VA operand [31:13].
- inv_busy  output  1  sweep in progress.
- inv_done  output  1  one-cycle pulse at sweep end.
- inv_err  output  1  one-cycle pulse: illegal op (>6), nothing changed.

## Operation
- Match(i, vppn, asid): E[i] & vppn[18:10]==VPPN[i][18:10] & (PS4M[i] | vppn[9:0]==VPPN[i][9:0]) & (G[i] | asid==ASID[i]).
- Multiple hits: lowest index wins. Odd page = PS4M ? vppn[9] : va_bit12. On a miss, all result fields are 0.
- Write: stores w_entry at w_index; ps==22 stores PS4M=1, any other value stores 12.
- Ops: 0,1 all entries; 2 G=1; 3 G=0; 4 G=0 & ASID match; 5 G=0 & ASID & VA match; 6 (G=1 | ASID match) & VA match. VA match ignores E.
- FSM IDLE -> SWEEP on inv_req with a legal op; operands are latched. SWEEP clears E on matching entries in lanes [k*INV_LANES, +INV_LANES), k=0..TLBNUM/INV_LANES-1. After the last group -> IDLE with inv_done. An illegal op stays IDLE and pulses inv_err next cycle.
- inv_req while busy is ignored. Searches and reads stay serviced during the sweep.
- If we and a sweep lane hit the same index in the same cycle, the write wins.

## Timing
- Reset: E[] all 0, FSM IDLE; all outputs 0. Other array fields are not reset.
- Search/read: inputs sampled at edge N; results are valid in cycle N+1. Outputs hold until the next request on that port; s_rvalid/r_valid are high only in the cycle after a request.
- A write at edge N is visible to requests sampled at edge N+1. A request at edge N sees pre-write contents.
- INVTLB latency: inv_busy rises the cycle after acceptance and stays high for TLBNUM/INV_LANES cycles. inv_done coincides with the falling edge of inv_busy. Clears are visible to searches sampled after each group's edge.
- resetn low mid-sweep: abort, E all 0, no done pulse.

## Structure
- tlb_pkg: TLB_ENTRY_W (89), field offsets for {e, vppn, ps, asid, g, ppn0, plv0, mat0, d0, v0, ppn1, plv1, mat1, d1, v1}, INVTLB op constants, PS_4K=12, PS_4M=22.
- Sub-module tlb_lookup: combinational match, priority encode and odd/even select; one instance per search port, registered in tlb_mp.

## Test plan
- Write idx 3 {E=1, vppn=0x12345, ps=12, asid=5, g=0, ppn0=0xAAAAA, ppn1=0xBBBBB}; search vppn 0x12345, bit12=1, asid 5 -> next cycle found=1, index=3, ppn=0xBBBBB, ps=12.
- Write 4MB entries at idx 2 and idx 7 with the same vppn[18:10] and g=1 -> search any asid with vppn[9]=0 returns index 2 and ppn0.
- Entry written with E=0 -> search misses; all result fields 0.
- Fill 16 entries, half g=1; inv_op=3 -> inv_busy for 4 cycles, inv_done pulses, only g=1 entries still hit. inv_op=7 -> inv_err, no change.
- During an inv_op=0 sweep, we to idx 1 in the lane-0 cycle -> idx 1 survives; all others miss after done.
- Assert resetn low mid-sweep -> all searches miss, inv_busy=0, no inv_done.
